alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares the single 32-bit ALU between two requesters (port 0 and port 1) using round-robin arbitration.
- Each request carries two operands and a 4-bit ALU control code.
- The block captures the winning request, drives the external combinational ALU from registered operands, and latches the result and flags.
- It returns them to the owning requester on a valid/ready response handshake.
- It sits between the datapath issue logic (or a coprocessor port) and the ALU.

Parameters:
- W, 32, operand/result width
- OPW, 4, ALU control code width
- FLW, 3, ALU flags width
- MAX_OP, 14, highest legal control code; codes above it are illegal

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  2  per-port request valid (bit i = port i)
- req_ready  output  2  per-port request accept
- req_a0, req_a1  input  W  operand A, port 0/1
- req_b0, req_b1  input  W  operand B, port 0/1
- req_op0, req_op1  input  OPW  ALU control code, port 0/1
- resp_valid  output  2  per-port response valid
- resp_ready  input  2  per-port response accept
- resp_result  output  W  registered result (shared bus, qualified by resp_valid)
- resp_flags  output  FLW  registered ALU flags
- resp_err  output  1  illegal-op indicator for current response
- alu_rega  output  W  to ALU rega
- alu_regb  output  W  to ALU regb
- alu_ctrl_s  output  OPW  to ALU alu_ctrl_s
- alu_result  input  W  from ALU result (combinational)
- alu_flags  input  FLW  from ALU flags
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, all outputs 0, owner=0, rr pointer gives port 0 priority. Reset mid-operation aborts; any pending response is dropped, never delivered.
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - Winner = the only valid port; if both valid, the port not served last (rr pointer).
  - req_ready[winner]=1 combinationally in that cycle only; req_ready=0 in all other states.
  - On the accepting edge, latch operands/op into opa/opb/opc, record owner, go EXEC.
  - No valid request: stay in IDLE.
- EXEC (1 cycle):
  - alu_rega/alu_regb/alu_ctrl_s = latched registers; they change only on acceptance.
  - On the edge, resp_result<=alu_result, resp_flags<=alu_flags, resp_err<=0, then go RESP.
  - If opc>MAX_OP: resp_result<=0, resp_flags<=0, resp_err<=1.
- RESP:
  - resp_valid[owner]=1 (registered); result/flags/err held stable.
  - When resp_ready[owner]=1 on an edge: resp_valid<=0, rr pointer<=~owner, go IDLE.
  - resp_ready on the non-owner port is ignored.
- Latency: accept edge N, EXEC edge N+1, resp_valid visible after N+1.
  - Minimum 3 cycles per operation (accept, execute, one response cycle with ready=1).
  - No new request is accepted until the response completes.
- Request-side hold: requesters hold valid/operands stable until ready.
  - A request dropped before acceptance is simply not served.
  - A request that is still valid after its response is treated as a new request.
- busy: 1 in EXEC and RESP.
- Starvation bound: with both ports continuously valid, the ports alternate strictly (0,1,0,1,...).
- No arithmetic is performed internally; widths pass through unchanged.

Test Plan:
- Bench ALU stub: result=rega+regb for op 0, rega-regb for op 1; flags[0]=(result==0).
- Single request: port0 a=5, b=3, op=0, resp_ready=1 → req_ready[0] high 1 cycle; resp_valid[0] 2 edges after acceptance; resp_result=8, flags=3'b000, resp_err=0.
- Simultaneous requests after reset:
  - port0 (5,3,op1) and port1 (7,7,op1) both valid → port0 served first (result 2).
  - Then port1 (result 0, flags[0]=1).
  - Grant order is 0,1,0,1 over four back-to-back requests.
- Response backpressure: port1 request with resp_ready[1]=0 for 5 cycles → resp_valid[1] held, result/flags stable, busy=1, port0 request not accepted until the cycle after resp_ready[1]=1.
- Illegal op: port0 op=15 → resp_err=1, resp_result=0, resp_flags=0; the next legal op 0 (5,3) returns 8 with err=0.
- Reset mid-operation: assert rst_n=0 in RESP → next cycle resp_valid=0, busy=0, all outputs 0, and a following simultaneous request grants port 0 first.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one external combinational ALU between two requesters
module alu_share_arb #(
    parameter int W      = 32,
    parameter int OPW    = 4,
    parameter int FLW    = 3,
    parameter int MAX_OP = 14
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [W-1:0]   req_a0,
    input  logic [W-1:0]   req_a1,
    input  logic [W-1:0]   req_b0,
    input  logic [W-1:0]   req_b1,
    input  logic [OPW-1:0] req_op0,
    input  logic [OPW-1:0] req_op1,
    output logic [1:0]     resp_valid,
    input  logic [1:0]     resp_ready,
    output logic [W-1:0]   resp_result,
    output logic [FLW-1:0] resp_flags,
    output logic           resp_err,
    output logic [W-1:0]   alu_rega,
    output logic [W-1:0]   alu_regb,
    output logic [OPW-1:0] alu_ctrl_s,
    input  logic [W-1:0]   alu_result,
    input  logic [FLW-1:0] alu_flags,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam logic [OPW-1:0] MAXC = OPW'(MAX_OP);
    state_t         state_q, state_d;
    logic [W-1:0]   opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic [OPW-1:0] opc_q, opc_d;
    logic [FLW-1:0] flg_q, flg_d;
    logic           err_q, err_d, owner_q, owner_d, rr_q, rr_d, win;
    logic [1:0]     rv_q, rv_d, grant;
    always_comb begin
        win     = (req_valid == 2'b11) ? rr_q : req_valid[1];
        grant   = (state_q == IDLE && |req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        opc_d   = opc_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        res_d   = res_q;
        flg_d   = flg_q;
        err_d   = err_q;
        rv_d    = rv_q;
        case (state_q)
            IDLE: if (|req_valid) begin
                opa_d   = win ? req_a1 : req_a0;
                opb_d   = win ? req_b1 : req_b0;
                opc_d   = win ? req_op1 : req_op0;
                owner_d = win;
                state_d = EXEC;
            end
            EXEC: begin
                // Illegal codes never expose whatever the ALU produced for them
                err_d   = opc_q > MAXC;
                res_d   = err_d ? '0 : alu_result;
                flg_d   = err_d ? '0 : alu_flags;
                rv_d    = owner_q ? 2'b10 : 2'b01;
                state_d = RESP;
            end
            RESP: if (resp_ready[owner_q]) begin
                rv_d    = 2'b00;
                rr_d    = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            opc_q   <= '0;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            res_q   <= '0;
            flg_q   <= '0;
            err_q   <= 1'b0;
            rv_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            opc_q   <= opc_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            err_q   <= err_d;
            rv_q    <= rv_d;
        end
    end
    assign req_ready   = grant;
    assign resp_valid  = rv_q;
    assign resp_result = res_q;
    assign resp_flags  = flg_q;
    assign resp_err    = err_q;
    assign alu_rega    = opa_q;
    assign alu_regb    = opb_q;
    assign alu_ctrl_s  = opc_q;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: vector table, reset-abort sequence and randomized transactions against a transaction-level model
module tb_alu_share_arb;
    logic        clk = 0, rst_n = 0;
    logic [1:0]  req_valid = 0, req_ready, resp_valid, resp_ready = 0;
    logic [31:0] req_a0 = 0, req_a1 = 0, req_b0 = 0, req_b1 = 0;
    logic [3:0]  req_op0 = 0, req_op1 = 0, alu_ctrl_s;
    logic [31:0] resp_result, alu_rega, alu_regb, alu_result;
    logic [2:0]  resp_flags, alu_flags;
    logic        resp_err, busy;
    int checks = 0, errors = 0;

    alu_share_arb dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err),
        .alu_rega(alu_rega), .alu_regb(alu_regb), .alu_ctrl_s(alu_ctrl_s),
        .alu_result(alu_result), .alu_flags(alu_flags), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU stub: add, subtract, otherwise xor
    assign alu_result = (alu_ctrl_s == 0) ? alu_rega + alu_regb :
                        (alu_ctrl_s == 1) ? alu_rega - alu_regb : alu_rega ^ alu_regb;
    assign alu_flags  = {2'b00, alu_result == 0};

    typedef struct {
        logic [1:0]  v;
        logic [31:0] a0, b0;
        logic [3:0]  op0;
        logic [31:0] a1, b1;
        logic [3:0]  op1;
        int          g;
        logic [31:0] r;
        logic [2:0]  f;
        logic        e;
        int          d;
        bit          oth;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic [1:0] v, input logic [31:0] a0, b0, input logic [3:0] op0,
                          input logic [31:0] a1, b1, input logic [3:0] op1, input int g,
                          input logic [31:0] er, input logic [2:0] ef, input logic ee,
                          input int dly, input bit oth);
        logic [1:0] oh;
        oh = (g == 1) ? 2'b10 : 2'b01;
        req_valid = v; req_a0 = a0; req_b0 = b0; req_op0 = op0;
        req_a1 = a1; req_b1 = b1; req_op1 = op1;
        #1;
        chk("grant", req_ready, oh);
        tick();
        req_valid[g] = 1'b0;
        if (oth) req_valid[1-g] = 1'b1;
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_resp_valid", resp_valid, 0);
        chk("exec_req_ready", req_ready, 0);
        chk("alu_rega", alu_rega, g ? a1 : a0);
        chk("alu_ctrl", alu_ctrl_s, g ? op1 : op0);
        tick();
        for (int i = 0; i < dly; i++) begin
            resp_ready = 2'($urandom_range(0, 3)) & ~oh;
            #1;
            chk("hold_resp_valid", resp_valid, oh);
            chk("hold_result", resp_result, er);
            chk("hold_flags", resp_flags, ef);
            chk("hold_busy", busy, 1);
            chk("hold_req_ready", req_ready, 0);
            tick();
        end
        resp_ready = oh | 2'($urandom_range(0, 3));
        #1;
        chk("resp_valid", resp_valid, oh);
        chk("resp_result", resp_result, er);
        chk("resp_flags", resp_flags, ef);
        chk("resp_err", resp_err, ee);
        tick();
        resp_ready = 0;
        #1;
        chk("done_resp_valid", resp_valid, 0);
        chk("done_busy", busy, 0);
    endtask

    function automatic logic [35:0] ref_alu(input logic [31:0] a, b, input logic [3:0] op);
        logic [31:0] r;
        if (op > 14) return 36'd0 | (36'd1 << 35);
        r = (op == 0) ? a + b : (op == 1) ? a - b : a ^ b;
        return {1'b0, 2'b00, r == 0, r};
    endfunction

    initial begin
        logic [31:0] pa[2], pb[2];
        logic [3:0]  po[2];
        bit          pend[2];
        int          last, g;
        logic [35:0] x;
        tbl[0]  = '{2'b11, 5, 3, 1, 7, 7, 1, 0, 2, 0, 0, 0, 0};
        tbl[1]  = '{2'b10, 5, 3, 1, 7, 7, 1, 1, 0, 1, 0, 0, 0};
        tbl[2]  = '{2'b11, 10, 4, 0, 1, 2, 0, 0, 14, 0, 0, 1, 0};
        tbl[3]  = '{2'b11, 10, 4, 0, 1, 2, 0, 1, 3, 0, 0, 0, 0};
        tbl[4]  = '{2'b01, 5, 3, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0};
        tbl[5]  = '{2'b10, 5, 3, 0, 9, 2, 1, 1, 7, 0, 0, 5, 1};
        tbl[6]  = '{2'b01, 5, 3, 0, 9, 2, 1, 0, 8, 0, 0, 0, 0};
        tbl[7]  = '{2'b01, 5, 3, 15, 0, 0, 0, 0, 0, 0, 1, 2, 0};
        tbl[8]  = '{2'b01, 5, 3, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0};
        tbl[9]  = '{2'b10, 0, 0, 0, 3, 3, 14, 1, 0, 1, 0, 0, 0};
        tbl[10] = '{2'b10, 0, 0, 0, 0, 1, 1, 1, 32'hFFFF_FFFF, 0, 0, 1, 0};
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_outputs", {resp_result, resp_flags, resp_err, alu_rega, alu_regb, alu_ctrl_s}, 0);
        rst_n = 1;
        tick();
        chk("idle_req_ready", req_ready, 0);
        foreach (tbl[i])
            do_txn(tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].op0, tbl[i].a1, tbl[i].b1, tbl[i].op1,
                   tbl[i].g, tbl[i].r, tbl[i].f, tbl[i].e, tbl[i].d, tbl[i].oth);
        // Abort a port-1 response by reset while port 1 holds round-robin priority
        do_txn(2'b01, 5, 3, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0);
        req_valid = 2'b10; req_a1 = 20; req_b1 = 1; req_op1 = 0;
        #1;
        chk("abort_grant", req_ready, 2'b10);
        tick();
        req_valid = 0;
        tick();
        chk("abort_resp_valid", resp_valid, 2'b10);
        rst_n = 0;
        tick();
        chk("abort_resp_valid_cleared", resp_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_outputs", {resp_result, resp_flags, resp_err, alu_rega, alu_regb, alu_ctrl_s}, 0);
        rst_n = 1;
        tick();
        chk("abort_no_late_resp", resp_valid, 0);
        do_txn(2'b11, 5, 3, 1, 7, 7, 1, 0, 2, 0, 0, 0, 0);
        // Randomized transactions: losers keep requesting, model tracks the last served port
        last = 0;
        pend[0] = 0; pend[1] = 1; pa[1] = 7; pb[1] = 7; po[1] = 1;
        for (int n = 0; n < 200; n++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(0, 1) == 1) begin
                    pend[p] = 1;
                    pa[p] = $urandom; pb[p] = ($urandom_range(0, 3) == 0) ? pa[p] : $urandom;
                    po[p] = ($urandom_range(0, 7) == 0) ? 4'(14 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
                end
            if (!pend[0] && !pend[1]) begin
                g = $urandom_range(0, 1);
                pend[g] = 1; pa[g] = $urandom; pb[g] = $urandom; po[g] = 4'($urandom_range(0, 15));
            end
            g = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
            x = ref_alu(pa[g], pb[g], po[g]);
            do_txn({pend[1], pend[0]}, pa[0], pb[0], po[0], pa[1], pb[1], po[1], g,
                   x[31:0], x[34:32], x[35], $urandom_range(0, 3), 0);
            pend[g] = 0;
            last = g;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
